// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - opcodes, funct codes, FSM states and ALU encoding for the multi-cycle MIPS core
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  function automatic logic [31:0] alu_eval(alu_op_e op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {31'd0, $signed(a) < $signed(b)};
      default: return a + b;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// rtl/mips_mc_regfile.sv - 32x32 register file, two async read ports, one sync write port, r0 reads zero
module mips_mc_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multi-cycle MIPS core with one shared ALU and one unified memory port
// Optional j instruction enabled by defining MIPS_MC_JUMP_EN.
module mips_multicycle_core
  import mips_mc_pkg::*;
#(
  parameter int               ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]      HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] pc_out,
  output logic              retire,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_next4, mem_addr_q, mem_addr_d;
  logic [31:0]       ir_q, ir_d, mdr_q, mdr_d, a_q, a_d, b_q, b_d, alu_out_q, alu_out_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic              retire_q, retire_d, halted_q, halted_d;

  logic [5:0]  opcode, funct;
  logic [31:0] imm_sext, imm_zext, br_off, pc4_32;
  logic        is_r, is_alu_i, is_lw, is_sw, is_beq;
  alu_op_e     r_op, alu_op;
  logic [31:0] alu_a, alu_b, alu_y;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, rs_val, rt_val;

  assign opcode   = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign imm_zext = {16'd0, ir_q[15:0]};
  assign br_off   = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign pc_next4 = pc_q + ADDR_W'(4);
  assign pc4_32   = 32'(pc_next4);

  assign is_alu_i = opcode inside {OP_ADDI, OP_ANDI, OP_ORI};
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);

`ifdef MIPS_MC_JUMP_EN
  logic [31:0] jump_tgt;
  assign jump_tgt = {pc4_32[31:28], ir_q[25:0], 2'b00};
`endif

  always_comb begin
    is_r = 1'b0;
    r_op = ALU_ADD;
    if (opcode == OP_RTYPE) begin
      is_r = 1'b1;
      case (funct)
        FN_ADD:  r_op = ALU_ADD;
        FN_SUB:  r_op = ALU_SUB;
        FN_AND:  r_op = ALU_AND;
        FN_OR:   r_op = ALU_OR;
        FN_SLT:  r_op = ALU_SLT;
        default: is_r = 1'b0;
      endcase
    end
  end

  // The single ALU forms the branch target in DECODE and the operation result in EXEC.
  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = a_q;
    alu_b  = b_q;
    case (state_q)
      DECODE: begin
        alu_a = pc4_32;
        alu_b = br_off;
      end
      EXEC: begin
        if (is_r) alu_op = r_op;
        else if (opcode == OP_ANDI) begin alu_op = ALU_AND; alu_b = imm_zext; end
        else if (opcode == OP_ORI)  begin alu_op = ALU_OR;  alu_b = imm_zext; end
        else if (is_beq)            alu_op = ALU_SUB;
        else                        alu_b  = imm_sext;
      end
      default: ;
    endcase
  end

  assign alu_y = alu_eval(alu_op, alu_a, alu_b);

  assign rf_waddr = is_r ? ir_q[15:11] : ir_q[20:16];
  assign rf_wdata = is_lw ? mdr_q : alu_out_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mdr_d     = mdr_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    retire_d  = 1'b0;
    rf_we     = 1'b0;
    case (state_q)
      FETCH: begin
        if (mem_req_q && mem_ready) begin
          ir_d    = mem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (ir_q == HALT_WORD) begin
          state_d  = HALT;
          retire_d = 1'b1;
        end else begin
          a_d       = rs_val;
          b_d       = rt_val;
          alu_out_d = alu_y;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        alu_out_d = alu_y;
        if (is_r || is_alu_i) begin
          state_d = WB;
        end else if (is_lw || is_sw) begin
          state_d = MEM;
        end else begin
          state_d  = FETCH;
          retire_d = 1'b1;
          pc_d     = pc_next4;
          if (is_beq && alu_y == '0) pc_d = alu_out_q[ADDR_W-1:0];
`ifdef MIPS_MC_JUMP_EN
          if (opcode == OP_J) pc_d = jump_tgt[ADDR_W-1:0];
`endif
        end
      end
      MEM: begin
        if (mem_req_q && mem_ready) begin
          if (is_sw) begin
            state_d  = FETCH;
            retire_d = 1'b1;
            pc_d     = pc_next4;
          end else begin
            mdr_d   = mem_rdata;
            state_d = WB;
          end
        end
      end
      WB: begin
        rf_we    = 1'b1;
        pc_d     = pc_next4;
        retire_d = 1'b1;
        state_d  = FETCH;
      end
      default: ;
    endcase

    // Memory outputs are derived from the next state so they are registered yet ready on entry.
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_d == FETCH) begin
      mem_req_d  = 1'b1;
      mem_addr_d = pc_d;
    end else if (state_d == MEM) begin
      mem_req_d  = 1'b1;
      mem_we_d   = is_sw;
      mem_addr_d = alu_out_d[ADDR_W-1:0];
      if (is_sw) mem_wdata_d = b_q;
    end
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      mdr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_out_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      retire_q    <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      mdr_q       <= mdr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_out_q   <= alu_out_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      retire_q    <= retire_d;
      halted_q    <= halted_d;
    end
  end

  mips_mc_regfile u_rf (
    .clk    (clk),
    .rst_n  (rst),
    .raddr1 (ir_q[25:21]),
    .raddr2 (ir_q[20:16]),
    .rdata1 (rs_val),
    .rdata2 (rt_val),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata)
  );

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc_out    = pc_q;
  assign retire    = retire_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb/tb_mips_multicycle_core.sv - directed bench for mips_multicycle_core with a variable-latency memory model
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, retire, halted;
  logic [31:0] mem_addr, mem_wdata, pc_out;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [0:255];
  int          delay = 0;
  int          wait_cnt = 0;
  int          cyc = 0;
  bit          prev_wait = 1'b0;
  logic        prev_we;
  logic [31:0] prev_addr, prev_wdata;
  logic [31:0] rd_q [$];
  logic [63:0] wr_q [$];
  int          ret_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_core dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .pc_out    (pc_out),
    .retire    (retire),
    .halted    (halted)
  );

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
      prev_wait = 1'b0;
    end else begin
      if (prev_wait && mem_req) begin
        chk("stable_addr", mem_addr, prev_addr);
        chk("stable_wdata", mem_wdata, prev_wdata);
        chk("stable_we", {31'd0, mem_we}, {31'd0, prev_we});
      end
      if (mem_req && wait_cnt >= delay) begin
        mem_ready = 1'b1;
        wait_cnt  = 0;
        if (mem_we) begin
          mem[mem_addr[9:2]] = mem_wdata;
          wr_q.push_back({mem_addr, mem_wdata});
        end else begin
          mem_rdata = mem[mem_addr[9:2]];
          rd_q.push_back(mem_addr);
        end
      end else if (mem_req) begin
        mem_ready = 1'b0;
        wait_cnt++;
      end else begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end
      prev_wait  = mem_req && !mem_ready;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      prev_we    = mem_we;
    end
    if (retire === 1'b1) ret_q.push_back(cyc);
  end

  function automatic logic [31:0] rd_at(int i);
    return (i < rd_q.size()) ? rd_q[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [63:0] wr_at(int i);
    return (i < wr_q.size()) ? wr_q[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic logic [31:0] gap(int i);
    return (i > 0 && i < ret_q.size()) ? 32'(ret_q[i] - ret_q[i-1]) : 32'hFFFF_FFFF;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'hFFFF_FFFF;
  endtask

  task automatic start(int dly);
    rst = 1'b0;
    delay = dly;
    @(negedge clk);
    @(negedge clk);
    rd_q.delete();
    wr_q.delete();
    ret_q.delete();
    rst = 1'b1;
  endtask

  task automatic wait_halt(string tag, int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, halted}, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_reads(string tag, int cnt, int budget);
    int n = 0;
    while (rd_q.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, rd_q.size() >= cnt}, 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_wr(string tag, int i, logic [31:0] addr, logic [31:0] data);
    logic [63:0] w;
    w = wr_at(i);
    chk({tag, "_addr"}, w[63:32], addr);
    chk({tag, "_data"}, w[31:0], data);
  endtask

  initial begin
    int   n;
    logic any_req;
    logic [31:0] exp_j;

    rst = 1'b1;
    clear_mem();
    #1 rst = 1'b0;
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);

    // A: ALU program, ready tied high
    clear_mem();
    mem[0] = 32'h2001_0005;
    mem[1] = 32'h2002_FFFD;
    mem[2] = 32'h0022_1820;
    start(0);
    @(posedge clk);
    #1;
    chk("A_first_req", {31'd0, mem_req}, 32'd1);
    chk("A_first_addr", mem_addr, 32'd0);
    wait_halt("A_halt", 200);
    chk("A_retire_count", 32'(ret_q.size()), 32'd4);
    chk("A_addi_cycles", gap(1), 32'd4);
    chk("A_add_cycles", gap(2), 32'd4);
    any_req = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any_req = any_req | mem_req;
    end
    chk("A_req_after_halt", {31'd0, any_req}, 32'd0);
    chk("A_still_halted", {31'd0, halted}, 32'd1);

    // B: store/load round trip with three wait cycles per access
    clear_mem();
    mem[0] = 32'h2001_0005;
    mem[1] = 32'h2002_FFFD;
    mem[2] = 32'h0022_1820;
    mem[3] = 32'hAC03_0008;
    mem[4] = 32'h8C04_0008;
    mem[5] = 32'hAC04_0040;
    start(3);
    wait_halt("B_halt", 600);
    chk("B_write_count", 32'(wr_q.size()), 32'd2);
    chk_wr("B_sw_r3", 0, 32'h8, 32'h2);
    chk_wr("B_sw_r4", 1, 32'h40, 32'h2);
    chk("B_addi_cycles", gap(1), 32'd7);
    chk("B_sw_cycles", gap(3), 32'd10);
    chk("B_lw_cycles", gap(4), 32'd11);

    // C: slt, andi, untaken beq, sub, or, ori
    clear_mem();
    mem[0]  = 32'h2001_0005;
    mem[1]  = 32'h2002_FFFD;
    mem[2]  = 32'h0041_282A;
    mem[3]  = 32'h3026_FFFF;
    mem[4]  = 32'h1022_FFFE;
    mem[5]  = 32'h0022_3822;
    mem[6]  = 32'h0022_4025;
    mem[7]  = 32'h3409_8000;
    mem[8]  = 32'hAC05_0040;
    mem[9]  = 32'hAC06_0044;
    mem[10] = 32'hAC07_0048;
    mem[11] = 32'hAC08_004C;
    mem[12] = 32'hAC09_0050;
    start(0);
    wait_halt("C_halt", 400);
    chk_wr("C_slt", 0, 32'h40, 32'h1);
    chk_wr("C_andi", 1, 32'h44, 32'h5);
    chk_wr("C_sub", 2, 32'h48, 32'h8);
    chk_wr("C_or", 3, 32'h4C, 32'hFFFF_FFFD);
    chk_wr("C_ori", 4, 32'h50, 32'h0000_8000);
    chk("C_beq_ne_next", rd_at(5), 32'h14);
    chk("C_beq_cycles", gap(4), 32'd3);

    // D: taken backward beq at 0x10
    clear_mem();
    mem[0] = 32'h2001_0005;
    mem[1] = 32'h0000_0000;
    mem[2] = 32'h0000_0000;
    mem[3] = 32'h0000_0000;
    mem[4] = 32'h1021_FFFE;
    start(0);
    wait_reads("D_reads", 6, 200);
    chk("D_beq_fetch", rd_at(4), 32'h10);
    chk("D_beq_eq_next", rd_at(5), 32'h0C);
    chk("D_beq_cycles", gap(4), 32'd3);

    // E: reset during the wait of a store
    clear_mem();
    mem[0] = 32'h2001_0005;
    mem[1] = 32'hAC01_0040;
    start(5);
    n = 0;
    while (!(mem_req === 1'b1 && mem_we === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("E_store_seen", {31'd0, mem_req && mem_we}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("E_req_async", {31'd0, mem_req}, 32'd0);
    chk("E_pc_reset", pc_out, 32'd0);
    chk("E_no_write", 32'(wr_q.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rd_q.delete();
    rst = 1'b1;
    wait_reads("E_refetch_seen", 1, 100);
    chk("E_refetch_addr", rd_at(0), 32'd0);

    // F: j 0x40 at PC 0
    clear_mem();
    mem[0] = 32'h0800_0040;
`ifdef MIPS_MC_JUMP_EN
    exp_j = 32'h100;
`else
    exp_j = 32'h4;
`endif
    start(0);
    wait_halt("F_halt", 200);
    chk("F_next_fetch", rd_at(1), exp_j);
    chk("F_retire_count", 32'(ret_q.size()), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
